// File: rtl/painterengine_gpu_reader_pkg.sv
// painterengine_gpu_reader_pkg: reader FSM states and AXI read constants
package painterengine_gpu_reader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int unsigned DEF_MAX_BURST = 16;
endpackage

// File: rtl/painterengine_gpu_reader_burstcalc.sv
// painterengine_gpu_reader_burstcalc: beats = min(remaining, max burst, words left in the 4 KB page)
module painterengine_gpu_reader_burstcalc
  import painterengine_gpu_reader_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic [9:0]  i_addr_word,
  input  logic [31:0] i_remaining,
  output logic [8:0]  o_beats
);
  logic [10:0] page_words;
  logic [8:0]  lim;
  // clamp by request size, then by the distance to the next 4 KB boundary
  always_comb begin
    page_words = 11'd1024 - {1'b0, i_addr_word};
    lim = (i_remaining < 32'(MAX_BURST)) ? i_remaining[8:0] : 9'(MAX_BURST);
    o_beats = ({2'b00, lim} < page_words) ? lim : page_words[8:0];
  end
endmodule

// File: rtl/painterengine_gpu_reader.sv
// painterengine_gpu_reader: turns an (address, length) session into AXI4 INCR read bursts and a word stream
module painterengine_gpu_reader
  import painterengine_gpu_reader_pkg::*;
#(
  parameter int unsigned PARAM_MAX_BURST = 16
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_session_resetn,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic [31:0] o_wire_m_axi_araddr,
  output logic [7:0]  o_wire_m_axi_arlen,
  output logic [2:0]  o_wire_m_axi_arsize,
  output logic [1:0]  o_wire_m_axi_arburst,
  output logic        o_wire_m_axi_arvalid,
  input  logic        i_wire_m_axi_arready,
  input  logic [31:0] i_wire_m_axi_rdata,
  input  logic [1:0]  i_wire_m_axi_rresp,
  input  logic        i_wire_m_axi_rlast,
  input  logic        i_wire_m_axi_rvalid,
  output logic        o_wire_m_axi_rready
);
  state_t      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic [8:0]  beats;
  logic        beat, last_beat;

  painterengine_gpu_reader_burstcalc #(.MAX_BURST(PARAM_MAX_BURST)) u_burstcalc (
    .i_addr_word (cur_addr_q[11:2]),
    .i_remaining (remaining_q),
    .o_beats     (beats)
  );

  assign o_wire_data          = i_wire_m_axi_rdata;
  assign o_wire_m_axi_arsize  = AXI_SIZE_4B;
  assign o_wire_m_axi_arburst = AXI_BURST_INCR;
  assign o_wire_m_axi_araddr  = araddr_q;
  assign o_wire_m_axi_arlen   = arlen_q;

  // handshake and status outputs decoded from the current state
  always_comb begin
    o_wire_m_axi_rready  = (state_q == ST_DATA) ? i_wire_data_next : (state_q == ST_DRAIN);
    o_wire_data_valid    = (state_q == ST_DATA) & i_wire_m_axi_rvalid & i_wire_data_next;
    o_wire_m_axi_arvalid = (state_q == ST_ADDR);
    o_wire_done          = (state_q == ST_DONE);
    o_wire_error         = (state_q == ST_ERROR);
    beat                 = i_wire_m_axi_rvalid & o_wire_m_axi_rready;
    last_beat            = (beat_cnt_q == 9'd1);
  end

  // next-state logic: one burst in flight, abort drains whatever was already requested
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    abort_d     = abort_q;
    case (state_q)
      ST_IDLE: if (i_wire_session_resetn) begin
        cur_addr_d  = i_wire_address;
        remaining_d = i_wire_length;
        err_d       = 1'b0;
        abort_d     = 1'b0;
        state_d     = ST_CHECK;
      end
      ST_CHECK: begin
        if (!i_wire_session_resetn) state_d = ST_IDLE;
        else if (cur_addr_q[1:0] != 2'b00) state_d = ST_ERROR;
        else if (remaining_q == 32'd0) state_d = ST_DONE;
        else begin
          araddr_d   = cur_addr_q;
          arlen_d    = 8'(beats - 9'd1);
          beat_cnt_d = beats;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        abort_d = abort_q | ~i_wire_session_resetn;
        if (i_wire_m_axi_arready) state_d = abort_d ? ST_DRAIN : ST_DATA;
      end
      ST_DATA: begin
        if (beat) begin
          cur_addr_d  = cur_addr_q + 32'd4;
          remaining_d = remaining_q - 32'd1;
          beat_cnt_d  = beat_cnt_q - 9'd1;
          err_d       = err_q | (i_wire_m_axi_rresp != 2'b00) | (i_wire_m_axi_rlast != last_beat);
        end
        if (!i_wire_session_resetn) state_d = ST_DRAIN;
        else if (beat && last_beat) state_d = err_d ? ST_ERROR : (remaining_q == 32'd1) ? ST_DONE : ST_CHECK;
      end
      ST_DRAIN: begin
        if (beat_cnt_q == 9'd0) state_d = ST_IDLE;
        else if (beat) beat_cnt_d = beat_cnt_q - 9'd1;
      end
      ST_DONE, ST_ERROR: if (!i_wire_session_resetn) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
    end
  end
endmodule

// File: tb/tb_painterengine_gpu_reader.sv
// tb_painterengine_gpu_reader: scoreboard bench with an AXI read slave model and burst-splitting reference
module tb_painterengine_gpu_reader;
  logic        clk = 1'b0, rst_n = 1'b0, sess = 1'b0, nxt = 1'b1;
  logic [31:0] addr = '0, len = '0;
  logic        arready = 1'b1, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        done, error, dv, arvalid, rready;
  logic [31:0] data, araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  painterengine_gpu_reader dut (
    .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_session_resetn(sess),
    .i_wire_address(addr), .i_wire_length(len),
    .o_wire_done(done), .o_wire_error(error), .o_wire_data(data), .o_wire_data_valid(dv),
    .i_wire_data_next(nxt),
    .o_wire_m_axi_araddr(araddr), .o_wire_m_axi_arlen(arlen), .o_wire_m_axi_arsize(arsize),
    .o_wire_m_axi_arburst(arburst), .o_wire_m_axi_arvalid(arvalid), .i_wire_m_axi_arready(arready),
    .i_wire_m_axi_rdata(rdata), .i_wire_m_axi_rresp(rresp), .i_wire_m_axi_rlast(rlast),
    .i_wire_m_axi_rvalid(rvalid), .o_wire_m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [39:0] exp_ar[$];
  logic [31:0] exp_w[$];
  logic [31:0] sl_addr[$];
  int          sl_beats[$];
  int sl_idx = 0, cyc = 0, ar_count = 0, r_count = 0, delivered = 0;
  int last_cyc = -1, done_cyc = -1, err_beat = -1, hold_at = -1, hold_cnt = 0;
  bit rnd_ar = 0, rnd_r = 0, rnd_next = 0, chk_bp = 0, done_prev = 0, rv_hold = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A11 ^ (a << 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // reference: split the request into page-safe bursts of at most 16 words
  task automatic model(input logic [31:0] a0, input int n);
    logic [31:0] a = a0;
    int rem = n, b, room;
    while (rem > 0) begin
      b = (rem < 16) ? rem : 16;
      room = (4096 - int'(a % 4096)) / 4;
      if (b > room) b = room;
      exp_ar.push_back({a, 8'(b - 1)});
      for (int i = 0; i < b; i++) exp_w.push_back(mem(a + 32'(4 * i)));
      a += 32'(4 * b);
      rem -= b;
    end
  endtask

  // bus driver (negedge) and monitor (negedge+3, well before the next posedge)
  initial forever begin
    logic [39:0] e;
    @(negedge clk);
    arready = rnd_ar ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (sl_addr.size() > 0) begin
      if (!rv_hold) rvalid = rnd_r ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdata = mem(sl_addr[0] + 32'(4 * sl_idx));
      rlast = (sl_idx == sl_beats[0] - 1);
      rresp = (r_count == err_beat) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
    end
    if (hold_at >= 0 && delivered == hold_at) begin hold_cnt = 10; hold_at = -1; end
    nxt = (hold_cnt > 0) ? 1'b0 : (rnd_next ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (hold_cnt > 0) hold_cnt--;
    #3;
    if (chk_bp && !nxt) begin
      chk("bp_rready", rready, 0);
      chk("bp_data_valid", dv, 0);
    end
    if (arvalid && arready) begin
      ar_count++;
      if (exp_ar.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ar: got addr %h len %h want no request", araddr, arlen);
      end else begin
        e = exp_ar.pop_front();
        chk("araddr", araddr, e[39:8]);
        chk("arlen", arlen, e[7:0]);
      end
      chk("ar_const", {arsize, arburst}, {3'b010, 2'b01});
      sl_addr.push_back(araddr);
      sl_beats.push_back(int'(arlen) + 1);
    end
    if (rvalid && rready) begin
      r_count++;
      rv_hold = 0;
      sl_idx++;
      if (sl_idx == sl_beats[0]) begin
        sl_idx = 0;
        void'(sl_addr.pop_front());
        void'(sl_beats.pop_front());
      end
    end else rv_hold = rvalid;
    if (dv) begin
      delivered++;
      if (exp_w.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word: got %h want none", data);
      end else begin
        chk("data", data, exp_w.pop_front());
        if (exp_w.size() == 0) last_cyc = cyc;
      end
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
    cyc++;
  end

  task automatic run(input logic [31:0] a, input int n, input bit want_err, input bit chk_lat);
    int t = 0;
    r_count = 0; delivered = 0; last_cyc = -1; done_cyc = -1;
    model(a, n);
    @(negedge clk);
    addr = a; len = n; sess = 1'b1;
    if (chk_lat) begin
      @(negedge clk); #4; chk("lat_cycle1_arvalid", arvalid, 0);
      @(negedge clk); #4; chk("lat_cycle2_arvalid", arvalid, 1);
    end
    while (!(done || error) && t < 4000) begin @(negedge clk); #4; t++; end
    chk("done", done, !want_err);
    chk("error", error, want_err);
    chk("words_left", exp_w.size(), 0);
    chk("bursts_left", exp_ar.size(), 0);
    if (!want_err) chk("done_latency", done_cyc - last_cyc, 1);
    @(negedge clk); sess = 1'b0;
    @(negedge clk); #4; chk("closed", {done, error}, 0);
    exp_w.delete(); exp_ar.delete();
  endtask

  task automatic instant(input logic [31:0] a, input logic [31:0] n, input bit want_err);
    int ar0 = ar_count;
    @(negedge clk);
    addr = a; len = n; sess = 1'b1;
    @(negedge clk); #4; chk("cycle1_flags", {done, error}, 0);
    @(negedge clk); #4; chk("cycle2_flags", {done, error}, want_err ? 2'b01 : 2'b10);
    repeat (3) @(negedge clk);
    #4;
    chk("flags_held", {done, error}, want_err ? 2'b01 : 2'b10);
    chk("no_arvalid", ar_count - ar0, 0);
    @(negedge clk); sess = 1'b0;
    @(negedge clk); #4; chk("instant_closed", {done, error}, 0);
  endtask

  initial begin
    int t;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_flags", {done, error, arvalid, rready, dv}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    @(negedge clk); rst_n = 1'b1;
    run(32'h0000_1000, 64, 0, 1);
    run(32'h0000_0FF8, 5, 0, 0);
    chk_bp = 1; hold_at = 6;
    run(32'h0000_4000, 16, 0, 0);
    chk_bp = 0;
    err_beat = 2;
    run(32'h0000_5000, 16, 1, 0);
    err_beat = -1;
    r_count = 0; delivered = 0;
    model(32'h0000_3000, 16);
    @(negedge clk);
    addr = 32'h0000_3000; len = 16; sess = 1'b1;
    t = 0;
    while (delivered < 4 && t < 200) begin @(negedge clk); t++; end
    sess = 1'b0;
    t = 0;
    while (r_count < 16 && t < 200) begin @(negedge clk); #4; t++; end
    repeat (3) @(negedge clk);
    #4;
    chk("abort_delivered", delivered, 5);
    chk("abort_beats", r_count, 16);
    chk("abort_drained", r_count - delivered, 11);
    chk("abort_bursts_left", exp_ar.size(), 0);
    chk("abort_idle", {done, error, arvalid, rready}, 0);
    exp_w.delete();
    run(32'h0000_2000, 4, 0, 0);
    instant(32'h0000_1000, 0, 0);
    instant(32'h0000_1002, 8, 1);
    rnd_ar = 1; rnd_r = 1; rnd_next = 1;
    for (int k = 0; k < 8; k++) begin
      a = (k % 2 == 0) ? 32'h0000_6000 - 32'(4 * $urandom_range(1, 20)) : 32'($urandom_range(0, 32'h3FFF)) & ~32'h3;
      run(a, $urandom_range(1, 50), 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
